// File: rtl/p4_operand_sequencer.sv
// Operand sequencer for the P4 adder: registers operands, waits a fixed settle
// time, captures sum/carry/overflow and holds them until downstream accepts.
package p4_pkg;
  localparam int unsigned NBIT = 32;
endpackage

module p4_operand_sequencer
  import p4_pkg::*;
#(
  parameter int unsigned nbit          = NBIT,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [nbit-1:0] in_a,
  input  logic [nbit-1:0] in_b,
  input  logic            in_cin,
  output logic [nbit-1:0] a,
  output logic [nbit-1:0] b,
  output logic            cin,
  input  logic [nbit-1:0] s,
  input  logic            cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [nbit-1:0] out_s,
  output logic            out_cout,
  output logic            out_ovf,
  output logic [15:0]     op_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OPC_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [nbit-1:0]    a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d;
  logic [nbit-1:0]    out_s_q, out_s_d;
  logic               out_cout_q, out_cout_d;
  logic               out_ovf_q, out_ovf_d;
  logic [OPC_W-1:0]   op_count_q, op_count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_c;

  // Signed overflow: like-signed operands producing a differently-signed sum
  assign ovf_c = (a_q[nbit-1] == b_q[nbit-1]) && (s[nbit-1] != a_q[nbit-1]);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    out_s_d     = out_s_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    op_count_d  = op_count_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          out_s_d    = s;
          out_cout_d = cout;
          out_ovf_d  = ovf_c;
          cnt_d      = '0;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          op_count_d = op_count_q + OPC_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      op_count_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      out_s_q     <= out_s_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      op_count_q  <= op_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign cin       = cin_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_p4_operand_sequencer.sv
// Directed bench for p4_operand_sequencer: SETTLE_CYCLES=1 and =4 instances,
// each closed around a behavioural adder.
module tb_p4_operand_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance with SETTLE_CYCLES = 1
  logic        rst, in_valid, in_cin, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, cin, out_valid, out_cout, out_ovf, cout;
  logic [31:0] a, b, s, out_s;
  logic [15:0] op_count;
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

  p4_operand_sequencer #(.nbit(32), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_cout(out_cout), .out_ovf(out_ovf), .op_count(op_count)
  );

  // Instance with SETTLE_CYCLES = 4
  logic        rst4, in_valid4, in_cin4, out_ready4;
  logic [31:0] in_a4, in_b4;
  logic        in_ready4, cin4, out_valid4, out_cout4, out_ovf4, cout4;
  logic [31:0] a4, b4, s4, out_s4;
  logic [15:0] op_count4;
  assign {cout4, s4} = {1'b0, a4} + {1'b0, b4} + {32'd0, cin4};

  p4_operand_sequencer #(.nbit(32), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_s(out_s4), .out_cout(out_cout4), .out_ovf(out_ovf4), .op_count(op_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1;
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    in_a = 32'hDEADBEEF; in_b = 32'h12345678; in_cin = 1'b1;
    in_a4 = '0; in_b4 = '0; in_cin4 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst4 = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: got %b expected 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({a, b, cin, out_s, out_cout, out_ovf, op_count} !== '0) begin
      n_fail++; $display("FAIL reset_regs: a=%h b=%h cin=%b s=%h co=%b ovf=%b cnt=%0d expected all 0",
                         a, b, cin, out_s, out_cout, out_ovf, op_count);
    end
    n_checks++;
    if ({in_ready4, out_valid4, op_count4} !== {2'b10, 16'd0}) begin
      n_fail++; $display("FAIL reset_dut4: rdy=%b vld=%b cnt=%0d expected 1 0 0",
                         in_ready4, out_valid4, op_count4);
    end
  endtask

  // One transaction on the SETTLE=1 instance, checking latency and results
  task automatic run_txn(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc, input logic [31:0] exp_s, input logic exp_co,
                         input logic exp_ovf, input logic [15:0] exp_cnt);
    in_a = ta; in_b = tb_; in_cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, a, b, cin} !== {2'b00, ta, tb_, tc}) begin
      n_fail++; $display("FAIL %s_accept: rdy=%b vld=%b a=%h b=%h cin=%b expected 0 0 %h %h %b",
                         name, in_ready, out_valid, a, b, cin, ta, tb_, tc);
    end
    tick();
    n_checks++;
    if ({out_valid, out_s, out_cout, out_ovf} !== {1'b1, exp_s, exp_co, exp_ovf}) begin
      n_fail++; $display("FAIL %s_result: vld=%b s=%h co=%b ovf=%b expected 1 %h %b %b",
                         name, out_valid, out_s, out_cout, out_ovf, exp_s, exp_co, exp_ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, op_count} !== {2'b10, exp_cnt}) begin
      n_fail++; $display("FAIL %s_done: rdy=%b vld=%b cnt=%0d expected 1 0 %0d",
                         name, in_ready, out_valid, op_count, exp_cnt);
    end
  endtask

  task automatic test_basic();
    run_txn("one_plus_one", 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 16'd1);
  endtask

  task automatic test_carry_ovf();
    run_txn("carry", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 16'd2);
    run_txn("ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 16'd3);
    run_txn("neg_ovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 16'd4);
  endtask

  task automatic test_hold_stall();
    in_a = 32'h00000010; in_b = 32'h00000020; in_cin = 1'b1; in_valid = 1'b1;
    tick(); tick();
    in_a = 32'hAAAAAAAA; in_b = 32'h55555555; in_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({out_valid, in_ready, out_s, a, b} !== {2'b10, 32'h00000031, 32'h10, 32'h20}) begin
        n_fail++; $display("FAIL stall_%0d: vld=%b rdy=%b s=%h a=%h b=%h expected 1 0 00000031 00000010 00000020",
                           i, out_valid, in_ready, out_s, a, b);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, op_count} !== {2'b10, 16'd5}) begin
      n_fail++; $display("FAIL stall_release: rdy=%b vld=%b cnt=%0d expected 1 0 5",
                         in_ready, out_valid, op_count);
    end
  endtask

  task automatic test_settle4();
    in_a4 = 32'h12345678; in_b4 = 32'h11111111; in_cin4 = 1'b1; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if ({out_valid4, in_ready4, a4, b4, cin4} !== {2'b00, 32'h12345678, 32'h11111111, 1'b1}) begin
        n_fail++; $display("FAIL settle4_wait_%0d: vld=%b rdy=%b a=%h b=%h cin=%b expected 0 0 12345678 11111111 1",
                           k, out_valid4, in_ready4, a4, b4, cin4);
      end
    end
    tick();
    n_checks++;
    if ({out_valid4, out_s4, out_cout4, out_ovf4, a4} !== {1'b1, 32'h2345678A, 1'b0, 1'b0, 32'h12345678}) begin
      n_fail++; $display("FAIL settle4_capture: vld=%b s=%h co=%b ovf=%b a=%h expected 1 2345678a 0 0 12345678",
                         out_valid4, out_s4, out_cout4, out_ovf4, a4);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    n_checks++;
    if ({in_ready4, out_valid4, op_count4} !== {2'b10, 16'd1}) begin
      n_fail++; $display("FAIL settle4_done: rdy=%b vld=%b cnt=%0d expected 1 0 1",
                         in_ready4, out_valid4, op_count4);
    end
  endtask

  task automatic test_reset_mid_settle();
    in_a = 32'h0000FFFF; in_b = 32'h00000001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, a, b, op_count} !== {2'b10, 32'd0, 32'd0, 16'd0}) begin
      n_fail++; $display("FAIL rst_settle: rdy=%b vld=%b a=%h b=%h cnt=%0d expected 1 0 0 0 0",
                         in_ready, out_valid, a, b, op_count);
    end
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL rst_settle_idle: rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
    run_txn("after_rst", 32'h00000003, 32'h00000004, 1'b1, 32'h00000008, 1'b0, 1'b0, 16'd1);
  endtask

  task automatic test_back_to_back();
    int acc_cyc [3];
    int accepts = 0;
    int cyc = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_a = 32'h00000005; in_b = 32'h00000006; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30 && accepts < 3; i++) begin
      if (in_ready) begin
        acc_cyc[accepts] = cyc;
        accepts++;
      end
      tick();
      cyc++;
      if (accepts == 3) in_valid = 1'b0;
    end
    n_checks++;
    if (accepts != 3) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", accepts);
    end else begin
      n_checks++;
      if ((acc_cyc[1] - acc_cyc[0]) != 3 || (acc_cyc[2] - acc_cyc[1]) != 3) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d,%0d expected 3,3",
                           acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
    tick(); tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, op_count, out_s} !== {2'b10, 16'd3, 32'h0000000B}) begin
      n_fail++; $display("FAIL b2b_done: rdy=%b vld=%b cnt=%0d s=%h expected 1 0 3 0000000b",
                         in_ready, out_valid, op_count, out_s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_hold_stall();
    test_settle4();
    test_reset_mid_settle();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
